io_timer_irq: RTL

//   16-bit programmable down-counter timer with prescaler and maskable interrupt.

---
 rtl/glu_io_pkg.sv | 23 ++
 rtl/timer_prescaler.sv | 28 ++
 rtl/io_timer_irq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/glu_io_pkg.sv
// Shared constants for the I/O glue slot peripherals: register offsets, control/status bit
// positions and the IOSEL slot decode range.
package glu_io_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_RLD_LO   = 3'd2;
  localparam logic [2:0] REG_RLD_HI   = 3'd3;
  localparam logic [2:0] REG_CNT_LO   = 3'd4;
  localparam logic [2:0] REG_CNT_HI   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  localparam int unsigned EN_B   = 0;
  localparam int unsigned AUTO_B = 1;
  localparam int unsigned IE_B   = 2;
  localparam int unsigned TF_B   = 0;

  localparam logic [15:0] IOSEL1_BASE = 16'hD100;
  localparam logic [15:0] IOSEL2_BASE = 16'hD200;
  localparam logic [15:0] IOSEL2_LAST = 16'hD2FF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for io_timer_irq: emits one tick every div+1 enabled PHI2 falling edges.
module timer_prescaler (
  input  logic       PHI2,
  input  logic       RESETn,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] r_pcnt;
  logic       w_hit;

  assign w_hit = (r_pcnt == div);
  // A restart on the same edge swallows the tick so the new count is not decremented.
  assign tick  = en & w_hit & ~restart;

  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_pcnt <= 8'd0;
    end else if (!en || restart || w_hit) begin
      r_pcnt <= 8'd0;
    end else begin
      r_pcnt <= r_pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/io_timer_irq.sv
// 16-bit prescaled down-counter timer on IOSEL2 with one-shot/auto-reload modes, a sticky
// expiry flag and an open-drain interrupt. All state changes on the falling edge of PHI2.
module io_timer_irq
  import glu_io_pkg::*;
#(
  parameter logic [7:0]  PRESCALE_RST = 8'd0,
  parameter logic [15:0] RELOAD_RST   = 16'hFFFF
) (
  input  logic       PHI2,
  input  logic       RESETn,
  input  logic       CSn,
  input  logic       RWn,
  input  logic [2:0] ADDR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       IRQn
);

  logic [2:0]  r_ctrl;
  logic        r_tf;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [7:0]  r_prescale;
  logic [7:0]  r_cnt_hi_snap;

  logic w_wr;
  logic w_rd;
  logic w_restart;
  logic w_tick;
  logic w_expire;

  assign w_wr      = ~CSn & ~RWn;
  assign w_rd      = ~CSn & RWn;
  assign w_restart = w_wr & (ADDR == REG_RLD_HI);
  assign w_expire  = w_tick & (r_count == 16'd0);

  timer_prescaler u_prescaler (
    .PHI2    (PHI2),
    .RESETn  (RESETn),
    .en      (r_ctrl[EN_B]),
    .restart (w_restart),
    .div     (r_prescale),
    .tick    (w_tick)
  );

  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_ctrl <= 3'b000;
    end else if (w_wr && (ADDR == REG_CTRL)) begin
      r_ctrl <= DIN[2:0];
    end else if (w_expire && !r_ctrl[AUTO_B]) begin
      r_ctrl[EN_B] <= 1'b0;
    end
  end

  // Expiry takes priority over a write-1-to-clear on the same edge.
  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_tf <= 1'b0;
    end else if (w_expire) begin
      r_tf <= 1'b1;
    end else if (w_wr && (ADDR == REG_STATUS) && DIN[TF_B]) begin
      r_tf <= 1'b0;
    end
  end

  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_reload   <= RELOAD_RST;
      r_prescale <= PRESCALE_RST;
    end else if (w_wr) begin
      if (ADDR == REG_RLD_LO)   r_reload[7:0]  <= DIN;
      if (ADDR == REG_RLD_HI)   r_reload[15:8] <= DIN;
      if (ADDR == REG_PRESCALE) r_prescale     <= DIN;
    end
  end

  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_count <= RELOAD_RST;
    end else if (w_restart) begin
      r_count <= {DIN, r_reload[7:0]};
    end else if (w_tick) begin
      if (r_count != 16'd0) begin
        r_count <= r_count - 16'd1;
      end else if (r_ctrl[AUTO_B]) begin
        r_count <= r_reload;
      end
    end
  end

  // Reading the low byte freezes the high byte so a two-byte read is coherent.
  always_ff @(negedge PHI2 or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt_hi_snap <= RELOAD_RST[15:8];
    end else if (w_rd && (ADDR == REG_CNT_LO)) begin
      r_cnt_hi_snap <= r_count[15:8];
    end
  end

  always_comb begin
    DOUT = 8'h00;
    if (!CSn) begin
      case (ADDR)
        REG_CTRL:     DOUT = {5'b00000, r_ctrl};
        REG_STATUS:   DOUT = {7'b0000000, r_tf};
        REG_RLD_LO:   DOUT = r_reload[7:0];
        REG_RLD_HI:   DOUT = r_reload[15:8];
        REG_CNT_LO:   DOUT = r_count[7:0];
        REG_CNT_HI:   DOUT = r_cnt_hi_snap;
        REG_PRESCALE: DOUT = r_prescale;
        default:      DOUT = 8'h00;
      endcase
    end
  end

  assign DOE  = ~CSn & RWn & PHI2;
  assign IRQn = (r_tf & r_ctrl[IE_B]) ? 1'b0 : 1'bz;

endmodule
